spram_wb: RTL and testbench

Parametrised single-port synchronous RAM with a Wishbone B4 pipelined slave interface and per-byte write enables. It is the successor to the fixed 32-bit simulation RAM used as Ibex instruction/data memory, and is generalised in data width, depth and read latency. It adds a post-reset clear sequence that zeroes the whole array, plus proper pipelined handshaking (stall/ack), so it can sit directly on the core's Wishbone instruction or data bus.

---
 rtl/spram_wb_pkg.sv | 13 +
 rtl/spram_core.sv | 32 +++
 rtl/spram_wb.sv | 128 ++++++++++++
 tb/tb_spram_wb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spram_wb_pkg.sv
// Shared types and helpers for the Wishbone single-port RAM.
package spram_wb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic int addr_width(input int size, input int data_width);
    return $clog2(size / (data_width / 8));
  endfunction

endpackage

// File: rtl/spram_core.sv
// Byte-enabled single-port storage array with a registered, read-first read port.
module spram_core
  import spram_wb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 1024,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [AW-1:0]         addr,
  input  logic                  ce,
  input  logic [BYTES-1:0]      be,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // q samples the word before this cycle's lane writes land (read-first)
  always_ff @(posedge clk) begin
    if (ce) begin
      q <= mem_q[addr];
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= d[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/spram_wb.sv
// Wishbone B4 pipelined slave RAM: post-reset clear sequence, ack pipeline, optional output stage.
module spram_wb
  import spram_wb_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int SIZE           = 32'h1000,
  parameter  int OUT_REG        = 0,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int BYTES          = DATA_WIDTH / 8,
  localparam int ADDR_WIDTH     = addr_width(SIZE, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc,
  input  logic                  stb,
  input  logic                  we,
  input  logic [BYTES-1:0]      sel,
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack,
  output logic                  stall
);

  localparam int DEPTH = SIZE / BYTES;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  clearing_s;
  logic                  accept_s;
  logic                  resp_s;
  logic                  v1_q;
  logic [ADDR_WIDTH-1:0] core_addr_s;
  logic                  core_ce_s;
  logic [BYTES-1:0]      core_be_s;
  logic [DATA_WIDTH-1:0] core_d_s;
  logic [DATA_WIDTH-1:0] core_q_s;

  assign stall      = (state_q == CLEAR);
  assign clearing_s = (state_q == CLEAR) && !rst;
  assign accept_s   = cyc && stb && (state_q == RUN) && !rst;
  // An in-flight response is only presented while the master still holds cyc
  assign resp_s     = v1_q && cyc;

  // CLEAR/RUN sequencing; the counter stops at DEPTH-1 instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt_q   <= '0;
    end else if (state_q == CLEAR) begin
      if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_q <= RUN;
      end else begin
        cnt_q <= cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    core_addr_s = adr;
    core_ce_s   = accept_s;
    core_be_s   = (accept_s && we) ? sel : '0;
    core_d_s    = dat_i;
    if (clearing_s) begin
      core_addr_s = cnt_q;
      core_ce_s   = 1'b1;
      core_be_s   = '1;
      core_d_s    = '0;
    end
  end

  // First response stage; dropping cyc kills it because accept requires cyc
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= accept_s;
    end
  end

  spram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_core (
    .clk (clk),
    .addr(core_addr_s),
    .ce  (core_ce_s),
    .be  (core_be_s),
    .d   (core_d_s),
    .q   (core_q_s)
  );

  if (OUT_REG != 0) begin : g_out_reg
    logic                  v2_q;
    logic [DATA_WIDTH-1:0] out_q;

    // Second stage delays ack and data by one cycle
    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q  <= 1'b0;
        out_q <= '0;
      end else begin
        v2_q <= resp_s;
        if (resp_s) begin
          out_q <= core_q_s;
        end
      end
    end

    assign ack   = v2_q && cyc;
    assign dat_o = out_q;
  end else begin : g_no_out_reg
    logic [DATA_WIDTH-1:0] hold_q;

    // Remembers the last acknowledged word so dat_o holds between acks
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q <= '0;
      end else if (resp_s) begin
        hold_q <= core_q_s;
      end
    end

    assign ack   = resp_s;
    assign dat_o = resp_s ? core_q_s : hold_q;
  end

endmodule

// File: tb/tb_spram_wb.sv
// Directed bench: u0 (OUT_REG=0, clear on reset, 1024 words), u1 (OUT_REG=1, no clear, 64 words).
module tb_spram_wb;

  logic        clk = 1'b0;
  logic        rst0 = 1'b0, cyc0 = 1'b0, stb0 = 1'b0, we0 = 1'b0;
  logic [3:0]  sel0 = 4'h0;
  logic [9:0]  adr0 = 10'd0;
  logic [31:0] dati0 = 32'h0, dato0;
  logic        ack0, stall0;
  logic        rst1 = 1'b0, cyc1 = 1'b0, stb1 = 1'b0, we1 = 1'b0;
  logic [3:0]  sel1 = 4'h0;
  logic [5:0]  adr1 = 6'd0;
  logic [31:0] dati1 = 32'h0, dato1;
  logic        ack1, stall1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  spram_wb #(.DATA_WIDTH(32), .SIZE(32'h1000), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst0), .cyc(cyc0), .stb(stb0), .we(we0), .sel(sel0), .adr(adr0),
    .dat_i(dati0), .dat_o(dato0), .ack(ack0), .stall(stall0)
  );

  spram_wb #(.DATA_WIDTH(32), .SIZE(32'h100), .OUT_REG(1), .CLEAR_ON_RESET(0)) u1 (
    .clk(clk), .rst(rst1), .cyc(cyc1), .stb(stb1), .we(we1), .sel(sel1), .adr(adr1),
    .dat_i(dati1), .dat_o(dato1), .ack(ack1), .stall(stall1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd0(input logic [9:0] a, output logic ack_o, output logic [31:0] d_o);
    step(); cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b0; adr0 = a; sel0 = 4'h0;
    step(); stb0 = 1'b0;
    @(negedge clk); ack_o = ack0; d_o = dato0;
    step(); cyc0 = 1'b0;
  endtask

  task automatic wr0(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic ack_o);
    step(); cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b1; adr0 = a; dati0 = d; sel0 = s;
    step(); stb0 = 1'b0; we0 = 1'b0;
    @(negedge clk); ack_o = ack0;
    step(); cyc0 = 1'b0;
  endtask

  task automatic count_stall0(output int n);
    n = 0;
    while (stall0 === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic        a;
    logic [31:0] d;
    int          n;
    logic [9:0]  addrs [3];
    addrs[0] = 10'd0; addrs[1] = 10'd511; addrs[2] = 10'd1023;
    rst0 = 1'b1; rst1 = 1'b1;
    step(); step();
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0)    begin errors++; $display("FAIL reset_ack0: got %b expected 0", ack0); end
    checks++; if (dato0 !== 32'h0)  begin errors++; $display("FAIL reset_dato0: got %h expected 0", dato0); end
    checks++; if (stall1 !== 1'b0)  begin errors++; $display("FAIL reset_stall1: got %b expected 0", stall1); end
    checks++; if (ack1 !== 1'b0)    begin errors++; $display("FAIL reset_ack1: got %b expected 0", ack1); end
    checks++; if (dato1 !== 32'h0)  begin errors++; $display("FAIL reset_dato1: got %h expected 0", dato1); end
    count_stall0(n);
    checks++; if (n != 1024) begin errors++; $display("FAIL clear_len: got %0d stall cycles expected 1024", n); end
    for (int i = 0; i < 3; i++) begin
      rd0(addrs[i], a, d);
      checks++; if (a !== 1'b1)   begin errors++; $display("FAIL clear_rd_ack[%0d]: got %b expected 1", addrs[i], a); end
      checks++; if (d !== 32'h0)  begin errors++; $display("FAIL clear_rd_data[%0d]: got %h expected 0", addrs[i], d); end
    end
  endtask

  task automatic test_byte_write();
    logic        a;
    logic [31:0] d;
    wr0(10'd5, 32'hDEADBEEF, 4'b0101, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL bw_wr_ack: got %b expected 1", a); end
    rd0(10'd5, a, d);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL bw_rd_ack: got %b expected 1", a); end
    checks++; if (d !== 32'h00AD00EF) begin errors++; $display("FAIL bw_rd_data: got %h expected 00ad00ef", d); end
  endtask

  task automatic test_read_first();
    logic        a;
    logic [31:0] d;
    step(); cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b1; adr0 = 10'd3; dati0 = 32'h1; sel0 = 4'hF;
    step(); dati0 = 32'h2;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL rf_ack1: got %b expected 1", ack0); end
    checks++; if (dato0 !== 32'h0) begin errors++; $display("FAIL rf_old0: got %h expected 0", dato0); end
    step(); stb0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL rf_ack2: got %b expected 1", ack0); end
    checks++; if (dato0 !== 32'h1) begin errors++; $display("FAIL rf_old1: got %h expected 1", dato0); end
    step(); cyc0 = 1'b0;
    rd0(10'd3, a, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL rf_new: got %h expected 2", d); end
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 11; k++) begin
        step();
        cyc1 = 1'b1; stb1 = (k < 8); we1 = (pass == 0); sel1 = 4'hF;
        adr1 = 6'(k); dati1 = 32'(k);
        @(negedge clk);
        exp_ack = (k >= 2 && k <= 9);
        checks++;
        if (ack1 !== exp_ack) begin
          errors++; $display("FAIL b2b_ack pass %0d cycle %0d: got %b expected %b", pass, k, ack1, exp_ack);
        end
        if (pass == 1 && exp_ack) begin
          checks++;
          if (dato1 !== 32'(k - 2)) begin
            errors++; $display("FAIL b2b_data cycle %0d: got %h expected %h", k, dato1, 32'(k - 2));
          end
        end
      end
      step(); cyc1 = 1'b0; stb1 = 1'b0; we1 = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic        a;
    logic [31:0] d;
    step(); cyc1 = 1'b1; stb1 = 1'b1; we1 = 1'b0; adr1 = 6'd1;
    step(); adr1 = 6'd2;
    @(negedge clk);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL abort_ack pre: got %b expected 0", ack1); end
    step(); cyc1 = 1'b0; stb1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL abort_ack cycle %0d: got %b expected 0", k, ack1); end
      step();
    end
    cyc1 = 1'b1; stb1 = 1'b1; adr1 = 6'd4;
    step(); stb1 = 1'b0;
    @(negedge clk);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL post_abort_lat: got %b expected 0", ack1); end
    step();
    @(negedge clk);
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL post_abort_ack: got %b expected 1", ack1); end
    checks++; if (dato1 !== 32'h4) begin errors++; $display("FAIL post_abort_data: got %h expected 4", dato1); end
    step(); cyc1 = 1'b0;
    // OUT_REG=0: a single accepted read whose response cycle has cyc low
    step(); cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b0; adr0 = 10'd5;
    step(); cyc0 = 1'b0; stb0 = 1'b0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL abort0_ack: got %b expected 0", ack0); end
    rd0(10'd5, a, d);
    checks++; if (d !== 32'h00AD00EF) begin errors++; $display("FAIL abort0_rd: got %h expected 00ad00ef", d); end
  endtask

  task automatic test_reset_mid_burst();
    logic        a;
    logic [31:0] d;
    int          n;
    wr0(10'd9, 32'h12345678, 4'hF, a);
    step(); cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b0; adr0 = 10'd9;
    step(); adr0 = 10'd10;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL mid_ack: got %b expected 1", ack0); end
    checks++; if (dato0 !== 32'h12345678) begin errors++; $display("FAIL mid_data: got %h expected 12345678", dato0); end
    rst0 = 1'b1;
    step(); rst0 = 1'b0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b expected 0", ack0); end
    checks++; if (dato0 !== 32'h0) begin errors++; $display("FAIL rst_mid_dato: got %h expected 0", dato0); end
    cyc0 = 1'b0; stb0 = 1'b0;
    count_stall0(n);
    checks++; if (n != 1024) begin errors++; $display("FAIL reclear_len: got %0d stall cycles expected 1024", n); end
    rd0(10'd9, a, d);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL reclear_ack: got %b expected 1", a); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reclear_data: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_read_first();
    test_back_to_back();
    test_abort();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
